aes_enc_iter_128: RTL and testbench

Iterative AES-128 encryption datapath. It performs one full round per clock.
The state register feeds the existing 128-bit SubBytes block (aes_sbox_128). The block then applies ShiftRows, MixColumns and AddRoundKey to that block's output and registers the result.
It sits between the host-side load interface and the ciphertext output stream. The round keys are expanded on the fly, so no key RAM is needed.

---
 rtl/aes_pkg.sv | 84 ++++++++
 rtl/aes_key_step_128.sv | 30 +++
 rtl/aes_sbox.sv | 25 ++
 rtl/aes_enc_iter_128.sv | 88 ++++++++
 tb/tb_aes_enc_iter_128.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/aes_pkg.sv
// aes_pkg: shared AES-128 definitions.
// Contents: FSM state type, round count NR, the Rcon lookup, GF(2^8) helpers,
// the S-box byte function, ShiftRows and the MixColumns column function.
// Byte order everywhere: byte i sits at bits [127-8i -: 8], column c is
// bits [127-32c -: 32], and row r of column c is byte 4c+r.
package aes_pkg;

  typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;

  localparam logic [3:0] NR = 4'd10;

  // Round constant for rounds 1..10; 0 elsewhere so rnd=0 is harmless.
  function automatic logic [7:0] rcon(input logic [3:0] rnd);
    case (rnd)
      4'd1:    rcon = 8'h01;
      4'd2:    rcon = 8'h02;
      4'd3:    rcon = 8'h04;
      4'd4:    rcon = 8'h08;
      4'd5:    rcon = 8'h10;
      4'd6:    rcon = 8'h20;
      4'd7:    rcon = 8'h40;
      4'd8:    rcon = 8'h80;
      4'd9:    rcon = 8'h1b;
      4'd10:   rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    xtime = {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    gf_mul = p;
  endfunction

  // S-box computed as the affine map of the field inverse. The inverse is
  // b^254 = b^2 * b^4 * ... * b^128, which maps 0 to 0 as AES requires.
  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [7:0] sq;
    logic [7:0] inv;
    sq  = gf_mul(b, b);
    inv = sq;
    for (int k = 2; k < 8; k++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    sbox = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
         ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] mix_column(input logic [31:0] w);
    logic [7:0] a0, a1, a2, a3;
    a0 = w[31:24];
    a1 = w[23:16];
    a2 = w[15:8];
    a3 = w[7:0];
    mix_column = {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                  a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                  a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                  xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  // Row r is rotated left by r columns: out(r,c) = in(r,(c+r) mod 4).
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
      end
    end
    shift_rows = o;
  endfunction

endpackage

// File: rtl/aes_key_step_128.sv
// aes_key_step_128: one combinational AES-128 key-schedule step.
// Ports: key - current round key w0..w3, rnd - round number selecting Rcon,
//        nk - next round key.
module aes_key_step_128
  import aes_pkg::*;
(
  input  logic [127:0] key,
  input  logic [3:0]   rnd,
  output logic [127:0] nk
);
  logic [31:0] w0, w1, w2, w3, sub, t, nk0, nk1, nk2, nk3;

  assign w0 = key[127:96];
  assign w1 = key[95:64];
  assign w2 = key[63:32];
  assign w3 = key[31:0];

  // RotWord feeds the word S-box directly.
  aes_sbox_word u_sbox_word (
    .din  ({w3[23:0], w3[31:24]}),
    .dout (sub)
  );

  assign t   = sub ^ {rcon(rnd), 24'h0};
  assign nk0 = w0 ^ t;
  assign nk1 = w1 ^ nk0;
  assign nk2 = w2 ^ nk1;
  assign nk3 = w3 ^ nk2;
  assign nk  = {nk0, nk1, nk2, nk3};
endmodule

// File: rtl/aes_sbox.sv
// aes_sbox_word / aes_sbox_128: combinational SubBytes over 4 and 16 bytes.
// Ports: din - input bytes, dout - substituted bytes (same byte positions).
module aes_sbox_word
  import aes_pkg::*;
(
  input  logic [31:0] din,
  output logic [31:0] dout
);
  always_comb begin
    dout = '0;
    for (int i = 0; i < 4; i++) dout[8*i +: 8] = sbox(din[8*i +: 8]);
  end
endmodule

module aes_sbox_128
  import aes_pkg::*;
(
  input  logic [127:0] din,
  output logic [127:0] dout
);
  always_comb begin
    dout = '0;
    for (int i = 0; i < 16; i++) dout[8*i +: 8] = sbox(din[8*i +: 8]);
  end
endmodule

// File: rtl/aes_enc_iter_128.sv
// aes_enc_iter_128: iterative AES-128 encryptor, one round per clock with
// on-the-fly key expansion.
// Ports: clk, rst (sync, active-high); in_valid/in_ready/in_text/in_key load
// side; out_valid/out_ready/out_text ciphertext side; busy high when not IDLE.
module aes_enc_iter_128
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_text,
  input  logic [127:0] in_key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_text,
  output logic         busy
);
  state_t       fsm;
  logic [3:0]   rnd;
  logic [127:0] state_q, key_q;
  logic [127:0] sb, sr, mc, nk, last_rnd;

  aes_sbox_128 u_sbox (
    .din  (state_q),
    .dout (sb)
  );

  aes_key_step_128 u_key_step (
    .key (key_q),
    .rnd (rnd),
    .nk  (nk)
  );

  assign sr       = shift_rows(sb);
  assign mc       = {mix_column(sr[127:96]), mix_column(sr[95:64]),
                     mix_column(sr[63:32]),  mix_column(sr[31:0])};
  assign last_rnd = sr ^ nk;

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm       <= IDLE;
      rnd       <= 4'd0;
      state_q   <= '0;
      key_q     <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_text  <= '0;
      busy      <= 1'b0;
    end else begin
      case (fsm)
        IDLE: begin
          if (in_valid) begin
            state_q  <= in_text ^ in_key;
            key_q    <= in_key;
            rnd      <= 4'd1;
            fsm      <= ROUND;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        ROUND: begin
          key_q <= nk;
          if (rnd == NR) begin
            state_q   <= last_rnd;
            out_text  <= last_rnd;
            out_valid <= 1'b1;
            rnd       <= 4'd0;
            fsm       <= DONE;
          end else begin
            state_q <= mc ^ nk;
            rnd     <= rnd + 4'd1;
          end
        end
        DONE: begin
          // out_text stays with the ciphertext until the next block finishes.
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            fsm       <= IDLE;
          end
        end
        default: fsm <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_aes_enc_iter_128.sv
module tb_aes_enc_iter_128;
  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_text;
  logic [127:0] in_key;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_text;
  logic         busy;

  int tests = 0;
  int fails = 0;

  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] B_R1   = 128'ha49c7ff2689f352b6b5bea43026a5049;

  aes_enc_iter_128 dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_text   (in_text),
    .in_key    (in_key),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_text  (out_text),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk128(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chkint(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Loads one block, measures latency and optionally checks round 1 state.
  // Leaves the DUT in DONE with out_ready low.
  task automatic load_and_wait(input logic [127:0] key, input logic [127:0] pt,
                               input logic [127:0] ct, input bit chk_r1);
    int cyc;
    @(negedge clk);
    chk1("ready_before_load", in_ready, 1'b1);
    in_valid = 1'b1;
    in_text  = pt;
    in_key   = key;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    in_text  = '0;
    in_key   = '0;
    cyc = 0;
    while (!out_valid && cyc < 50) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      if (chk_r1 && cyc == 1) chk128("round1_state", dut.state_q, B_R1);
    end
    chkint("latency", cyc, 10);
    chk128("ciphertext", out_text, ct);
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk1("hs_out_valid", out_valid, 1'b0);
    chk1("hs_in_ready", in_ready, 1'b1);
    chk1("hs_busy", busy, 1'b0);
  endtask

  initial begin
    int n_ct;
    int idle_gap;
    bit seen_first;
    logic [127:0] got [2];

    rst = 1'b1; in_valid = 1'b0; in_text = '0; in_key = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Reset values held across idle cycles
    for (int i = 0; i < 5; i++) begin
      chk1("rst_in_ready", in_ready, 1'b1);
      chk1("rst_out_valid", out_valid, 1'b0);
      chk128("rst_out_text", out_text, '0);
      chk1("rst_busy", busy, 1'b0);
      @(negedge clk);
    end

    // FIPS-197 C.1
    load_and_wait(C1_KEY, C1_PT, C1_CT, 1'b0);
    chk1("c1_busy_done", busy, 1'b1);
    handshake();
    chk128("out_text_kept", out_text, C1_CT);

    // FIPS-197 Appendix B with round-1 state check
    load_and_wait(B_KEY, B_PT, B_CT, 1'b1);
    handshake();

    // Backpressure: hold for 20 cycles, pulse in_valid meanwhile
    load_and_wait(C1_KEY, C1_PT, C1_CT, 1'b0);
    for (int i = 0; i < 20; i++) begin
      in_valid = i[0];
      in_text  = B_PT;
      in_key   = B_KEY;
      @(posedge clk);
      @(negedge clk);
      chk1("bp_out_valid", out_valid, 1'b1);
      chk128("bp_out_text", out_text, C1_CT);
      chk1("bp_in_ready", in_ready, 1'b0);
    end
    in_valid = 1'b0;
    handshake();
    @(posedge clk);
    @(negedge clk);
    chk1("bp_stays_idle", busy, 1'b0);

    // Back-to-back with in_valid held high and out_ready high
    in_valid = 1'b1; in_text = C1_PT; in_key = C1_KEY; out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_text = B_PT; in_key = B_KEY;
    n_ct = 0; idle_gap = 0; seen_first = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (out_valid && n_ct < 2) begin
        got[n_ct] = out_text;
        n_ct++;
        if (n_ct == 2) in_valid = 1'b0;
        seen_first = 1'b1;
      end else if (seen_first && n_ct == 1 && !busy) begin
        idle_gap++;
      end
      @(posedge clk);
      @(negedge clk);
    end
    out_ready = 1'b0;
    chkint("b2b_count", n_ct, 2);
    chk128("b2b_first", got[0], C1_CT);
    chk128("b2b_second", got[1], B_CT);
    chkint("b2b_idle_gap", idle_gap, 1);
    chk1("b2b_end_idle", busy, 1'b0);

    // Reset mid-round, then a clean C.1 block
    in_valid = 1'b1; in_text = C1_PT; in_key = C1_KEY;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chkint("mid_rnd", int'(dut.rnd), 5);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk1("mid_in_ready", in_ready, 1'b1);
    chk1("mid_out_valid", out_valid, 1'b0);
    chk1("mid_busy", busy, 1'b0);
    repeat (12) begin
      @(negedge clk);
      chk1("mid_no_output", out_valid, 1'b0);
    end
    load_and_wait(C1_KEY, C1_PT, C1_CT, 1'b0);
    handshake();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
